// File: rtl/keyb_matrix_scanner_if.sv
// Key-event handshake between the matrix scanner (master) and the key decoder (slave).
// The scanner presents a queued key event; the decoder accepts it with key_ready.
interface keyb_matrix_scanner_if #(
    parameter int KEY_W = 4
);
    logic             key_valid;
    logic [KEY_W-1:0] key_id;
    logic             key_rep;
    logic             key_ready;

    modport master (output key_valid, key_id, key_rep, input key_ready);
    modport slave  (input key_valid, key_id, key_rep, output key_ready);
endinterface

// File: rtl/keyb_matrix_scanner.sv
// Keypad matrix scanner: one-hot column strobe, synchronised row sense, frame debounce,
// multi-key lockout and an event FIFO. Define AUTO_REPEAT_EN to build the auto-repeat logic.
module keyb_matrix_scanner #(
    parameter int N_ROWS         = 4,
    parameter int N_COLS         = 4,
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_DELAY   = 8,
    parameter int REPEAT_RATE    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [N_COLS-1:0]     cols_out,
    input  logic [N_ROWS-1:0]     rows_in,
    keyb_matrix_scanner_if.master key_bus,
    output logic                  key_held,
    output logic                  key_overflow,
    input  logic                  ovf_clr
);
    localparam int KEY_W = $clog2(N_ROWS * N_COLS);
    localparam int COL_W = $clog2(N_COLS);
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // The repeat reload value DELAY-RATE must be non-negative, hence RATE <= DELAY.
    if (N_ROWS < 1 || N_COLS < 2 || SCAN_DIV < 3 || DEBOUNCE_SCANS < 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY)
    begin : g_bad_params
        $error("keyb_matrix_scanner: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD, S_REL} state_t;
    typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_t;

    logic [DIV_W-1:0]  div_cnt;
    logic [COL_W-1:0]  col_idx;
    logic [N_ROWS-1:0] rows_meta, rows_sync;
    logic              col_end, frame_end;

    assign col_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = col_end && (col_idx == COL_W'(N_COLS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            col_idx   <= '0;
            cols_out  <= N_COLS'(1);
            rows_meta <= '0;
            rows_sync <= '0;
        end else begin
            rows_meta <= rows_in;
            rows_sync <= rows_meta;
            div_cnt   <= col_end ? '0 : div_cnt + 1'b1;
            if (col_end) begin
                col_idx  <= frame_end ? '0 : col_idx + 1'b1;
                cols_out <= {cols_out[N_COLS-2:0], cols_out[N_COLS-1]};
            end
        end
    end

    // Closure counts saturate at 2, which maps directly onto frame_t.
    logic [1:0]       col_hits, acc_hits, merged_hits;
    logic [2:0]       hit_sum;
    logic [ROW_W-1:0] col_row;
    logic [KEY_W-1:0] col_key, acc_key, merged_key;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        col_hits = '0;
        col_row  = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (rows_sync[r]) begin
                col_row = ROW_W'(r);
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
        col_key     = KEY_W'(col_row) * KEY_W'(N_COLS) + KEY_W'(col_idx);
        hit_sum     = {1'b0, acc_hits} + {1'b0, col_hits};
        merged_hits = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        merged_key  = (acc_hits == 2'd0) ? col_key : acc_key;
    end

    logic             frame_vld;
    frame_t           frame_kind;
    logic [KEY_W-1:0] frame_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hits   <= '0;
            acc_key    <= '0;
            frame_vld  <= 1'b0;
            frame_kind <= FR_NONE;
            frame_key  <= '0;
        end else begin
            frame_vld <= frame_end;
            if (frame_end) begin
                frame_kind <= frame_t'(merged_hits);
                frame_key  <= merged_key;
                acc_hits   <= '0;
                acc_key    <= '0;
            end else if (col_end) begin
                acc_hits <= merged_hits;
                acc_key  <= merged_key;
            end
        end
    end

    state_t           state_q, state_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, single_match;
`ifdef AUTO_REPEAT_EN
    localparam int RC_W = $clog2(REPEAT_DELAY + 1);
    logic [RC_W-1:0] rep_cnt_q, rep_cnt_d;
    logic            push_rep;
`endif

    assign single_match = (frame_kind == FR_SINGLE) && (frame_key == cand_q);
    assign key_held     = (state_q == S_HELD) || (state_q == S_REL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
`ifdef AUTO_REPEAT_EN
        push_rep  = 1'b0;
        rep_cnt_d = rep_cnt_q;
`endif
        if (frame_vld) begin
            unique case (state_q)
                S_IDLE: if (frame_kind == FR_SINGLE) begin
                    cand_d  = frame_key;
                    cnt_d   = CNT_W'(1);
                    state_d = S_DEB;
                end
                S_DEB: if (!single_match) begin
                    state_d = S_IDLE;
                end else if (cnt_q + 1'b1 == CNT_W'(DEBOUNCE_SCANS)) begin
                    push    = 1'b1;
                    state_d = S_HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                S_HELD: if (frame_kind == FR_NONE) begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_REL;
`ifdef AUTO_REPEAT_EN
                    rep_cnt_d = '0;
                end else if (single_match) begin
                    if (rep_cnt_q == RC_W'(REPEAT_DELAY - 1)) begin
                        push      = 1'b1;
                        push_rep  = 1'b1;
                        rep_cnt_d = RC_W'(REPEAT_DELAY - REPEAT_RATE);
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end else if (frame_kind == FR_MULTI) begin
                    rep_cnt_d = '0;
`endif
                end
                S_REL: if (frame_kind != FR_NONE) begin
                    state_d = S_HELD;
                end else if (cnt_q + 1'b1 == CNT_W'(DEBOUNCE_SCANS)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic [KEY_W-1:0] id_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, do_pop, do_write, drop;

    assign full     = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign do_pop   = key_bus.key_valid && key_bus.key_ready;
    assign do_write = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;

    assign key_bus.key_valid = (count != '0);
    assign key_bus.key_id    = key_bus.key_valid ? id_mem[rd_ptr] : '0;

    // NOTE: storage is not reset; pointers and count define validity and outputs are masked.
    always_ff @(posedge clk) begin
        if (do_write) id_mem[wr_ptr] <= cand_q;
    end

`ifdef AUTO_REPEAT_EN
    logic rep_mem [FIFO_DEPTH];
    always_ff @(posedge clk) begin
        if (do_write) rep_mem[wr_ptr] <= push_rep;
    end
    assign key_bus.key_rep = key_bus.key_valid && rep_mem[rd_ptr];
`else
    assign key_bus.key_rep = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            key_overflow <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            if (do_write && !do_pop)      count <= count + 1'b1;
            else if (!do_write && do_pop) count <= count - 1'b1;
            // A drop in the same cycle as a clear wins.
            if (drop)         key_overflow <= 1'b1;
            else if (ovf_clr) key_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keyb_matrix_scanner.sv
// Scoreboard bench for keyb_matrix_scanner: directed key presses push expected events,
// a monitor pops and compares every accepted event. Runs test 6 when AUTO_REPEAT_EN is defined.
module tb_keyb_matrix_scanner;
    localparam int NR = 4;
    localparam int NC = 4;
`ifdef AUTO_REPEAT_EN
    localparam int HOLD1 = 120;
`else
    localparam int HOLD1 = 200;
`endif

    typedef struct packed {
        logic [3:0] id;
        logic       rep;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] cols_out;
    logic [NR-1:0] rows_in;
    logic          key_held, key_overflow, ovf_clr;
    logic [15:0]   pressed;

    keyb_matrix_scanner_if #(.KEY_W(4)) key_bus ();

    keyb_matrix_scanner dut (
        .clk          (clk),
        .reset        (reset),
        .cols_out     (cols_out),
        .rows_in      (rows_in),
        .key_bus      (key_bus),
        .key_held     (key_held),
        .key_overflow (key_overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows_in = '0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (cols_out[c] && pressed[r*NC+c]) rows_in[r] = 1'b1;
    end

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && key_bus.key_valid && key_bus.key_ready) begin
            check("event_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("event_id", int'(key_bus.key_id), int'(mon_e.id));
                check("event_rep", int'(key_bus.key_rep), int'(mon_e.rep));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 = key_valid, 1 = key_held
    task automatic wait_sig(input int which, input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (((which == 0) ? key_bus.key_valid : key_held) === val) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic press_release(input int id, input int hold);
        bit ok;
        pressed[id] = 1'b1;
        tick(hold);
        pressed[id] = 1'b0;
        wait_sig(1, 1'b0, 120, ok);
        check("release_settles", int'(ok), 1);
    endtask

    bit ok;
    bit held_seen, valid_seen;
    int keys4[5] = '{1, 2, 3, 5, 7};

    initial begin
        reset = 1'b1;
        ovf_clr = 1'b0;
        pressed = '0;
        key_bus.key_ready = 1'b1;
        tick(3);
        check("rst_cols", int'(cols_out), 1);
        check("rst_valid", int'(key_bus.key_valid), 0);
        check("rst_id", int'(key_bus.key_id), 0);
        check("rst_rep", int'(key_bus.key_rep), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_ovf", int'(key_overflow), 0);
        reset = 1'b0;

        // Column strobe: SCAN_DIV=4 cycles per column, wrapping after column 3.
        for (int i = 0; i < 20; i++) begin
            check("scan_cols", int'(cols_out), 1 << ((i / 4) % 4));
            tick(1);
        end

        // Test 1: single held key 13.
        sb.push_back('{id: 4'd13, rep: 1'b0});
        pressed[13] = 1'b1;
        wait_sig(0, 1'b1, 70, ok);
        check("t1_latency", int'(ok), 1);
        check("t1_held", int'(key_held), 1);
        tick(HOLD1 - 72);
        pressed[13] = 1'b0;
        tick(16);
        check("t1_held_after_1frame", int'(key_held), 1);
        tick(52);
        check("t1_released", int'(key_held), 0);
        check("t1_queue_drained", sb.size(), 0);

        // Test 2: key 4 bounces for one frame only.
        held_seen = 1'b0;
        valid_seen = 1'b0;
        pressed[4] = 1'b1;
        for (int i = 0; i < 112; i++) begin
            if (i == 16) pressed[4] = 1'b0;
            held_seen |= key_held;
            valid_seen |= key_bus.key_valid;
            tick(1);
        end
        check("t2_no_held", int'(held_seen), 0);
        check("t2_no_event", int'(valid_seen), 0);

        // Test 3: keys 0 and 6 together lock out; releasing 6 leaves a clean 0.
        held_seen = 1'b0;
        valid_seen = 1'b0;
        pressed[0] = 1'b1;
        pressed[6] = 1'b1;
        for (int i = 0; i < 96; i++) begin
            held_seen |= key_held;
            valid_seen |= key_bus.key_valid;
            tick(1);
        end
        check("t3_multi_no_held", int'(held_seen), 0);
        check("t3_multi_no_event", int'(valid_seen), 0);
        sb.push_back('{id: 4'd0, rep: 1'b0});
        pressed[6] = 1'b0;
        wait_sig(0, 1'b1, 70, ok);
        check("t3_single_event", int'(ok), 1);
        press_release(0, 16);
        check("t3_queue_drained", sb.size(), 0);

        // Test 4: FIFO overflow with the consumer stalled.
        key_bus.key_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) sb.push_back('{id: 4'(keys4[k]), rep: 1'b0});
            press_release(keys4[k], 80);
            if (k == 3) check("t4_full_no_ovf", int'(key_overflow), 0);
        end
        check("t4_ovf", int'(key_overflow), 1);
        check("t4_id_stable", int'(key_bus.key_id), 1);
        key_bus.key_ready = 1'b1;
        tick(1);
        wait_sig(0, 1'b0, 20, ok);
        check("t4_drained", int'(ok), 1);
        check("t4_queue_drained", sb.size(), 0);
        check("t4_ovf_sticky", int'(key_overflow), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", int'(key_overflow), 0);

        // Test 5: reset while HELD with two queued events.
        key_bus.key_ready = 1'b0;
        sb.push_back('{id: 4'd9, rep: 1'b0});
        press_release(9, 80);
        sb.push_back('{id: 4'd10, rep: 1'b0});
        pressed[10] = 1'b1;
        wait_sig(1, 1'b1, 70, ok);
        check("t5_held_before_reset", int'(ok), 1);
        check("t5_valid_before_reset", int'(key_bus.key_valid), 1);
        reset = 1'b1;
        pressed = '0;
        tick(1);
        reset = 1'b0;
        sb.delete();
        check("t5_valid", int'(key_bus.key_valid), 0);
        check("t5_held", int'(key_held), 0);
        check("t5_cols", int'(cols_out), 1);
        check("t5_ovf", int'(key_overflow), 0);
        check("t5_id", int'(key_bus.key_id), 0);
        key_bus.key_ready = 1'b1;
        valid_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            valid_seen |= key_bus.key_valid;
            tick(1);
        end
        check("t5_no_event_after_reset", int'(valid_seen), 0);

`ifdef AUTO_REPEAT_EN
        // Test 6: key 8 held 20 frames after HELD entry -> 1 press + 7 repeats.
        sb.push_back('{id: 4'd8, rep: 1'b0});
        for (int i = 0; i < 7; i++) sb.push_back('{id: 4'd8, rep: 1'b1});
        pressed[8] = 1'b1;
        wait_sig(1, 1'b1, 80, ok);
        check("t6_held", int'(ok), 1);
        tick(312);
        pressed[8] = 1'b0;
        wait_sig(1, 1'b0, 120, ok);
        check("t6_released", int'(ok), 1);
        tick(4);
        check("t6_queue_drained", sb.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
